// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder for the memory stage.
// A request is accepted in IDLE, waits LATENCY edges in BUSY, then raises a
// one-cycle response in RESP.  The pipeline is stalled while a request is
// accepted or outstanding, and released on the response cycle so that it
// captures resp_rdata.
// Optional build macro DMEM_POSTED_WRITE_EN: aligned writes commit on the
// accept edge and respond on the next cycle, bypassing BUSY.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        stall
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            wr_q, wr_d;
  logic            mis_q, mis_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;

  logic [31:0]     mem [DEPTH_WORDS];

  logic            req_mis;
  logic [AW-1:0]   req_idx;
  logic            accept;
  logic            posted;
  logic            access;
  logic            mem_we;
  logic [AW-1:0]   mem_widx;
  logic [31:0]     mem_wdata;
  logic [31:0]     mem_rdata;
  logic            unused_addr_hi;

  // Address decode: only the word index bits select a word, so addresses
  // alias modulo DEPTH_WORDS*4; the low two bits flag misalignment.
  assign req_mis        = |req_addr[1:0];
  assign req_idx        = req_addr[2 +: AW];
  assign unused_addr_hi = ^req_addr[31:AW+2];

  assign accept = (state_q == IDLE) && req_valid;
  assign access = (state_q == BUSY) && (cnt_q == '0);

`ifdef DMEM_POSTED_WRITE_EN
  // Aligned writes are committed directly on the accept edge.
  assign posted = accept && req_write && !req_mis;
`else
  assign posted = 1'b0;
`endif

  // A write commits either on the final BUSY edge or, when posted, on the
  // accept edge.  Reset blocks any commit so an aborted write never lands.
  assign mem_we    = !reset && (posted || (access && wr_q && !mis_q));
  assign mem_widx  = posted ? req_idx   : idx_q;
  assign mem_wdata = posted ? req_wdata : wdata_q;
  assign mem_rdata = mem[idx_q];

  // Backing array: no reset, contents survive a reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_widx] <= mem_wdata;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE -> BUSY -> RESP -> IDLE, with the posted-write
  // shortcut straight from IDLE to RESP.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = posted ? RESP : BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Request latch, wait counter and response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      mis_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      mis_q   <= mis_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Datapath next-state: latch on accept, count down in BUSY, produce the
  // response on the final BUSY edge, clear the error flag after RESP.
  always_comb begin
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    mis_d   = mis_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          wr_d    = req_write;
          mis_d   = req_mis;
          idx_d   = req_idx;
          wdata_d = req_wdata;
          cnt_d   = CW'(LATENCY - 1);
          if (posted) begin
            rdata_d = '0;
            err_d   = 1'b0;
          end
        end
      end
      BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          err_d   = mis_q;
          rdata_d = (mis_q || wr_q) ? 32'd0 : mem_rdata;
        end
      end
      RESP: begin
        err_d = 1'b0;
      end
      default: begin
        err_d = 1'b0;
      end
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    req_ready  = (state_q == IDLE);
    resp_valid = (state_q == RESP);
    stall      = (state_q == BUSY) || ((state_q == IDLE) && req_valid);
    resp_rdata = rdata_q;
    resp_err   = err_q;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed transactions, a deadline-based
// reference model of the responder, and a per-cycle output comparison.
module tb_dmem_responder;

  localparam int LAT   = 2;
  localparam int DEPTH = 256;
`ifdef DMEM_POSTED_WRITE_EN
  localparam bit POSTED = 1'b1;
`else
  localparam bit POSTED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr  = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        stall;

  int checks = 0;
  int passes = 0;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .reset(rst),
    .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: a request is either pending with a completion deadline
  // (in clock edges) or answered in the following cycle.
  logic [31:0] m_mem [0:DEPTH-1];
  bit          m_pend = 1'b0;
  bit          m_resp = 1'b0;
  int          cyc    = 0;
  int          m_done = 0;
  bit          m_w;
  logic [31:0] m_a, m_d;
  logic [31:0] m_rd = '0;
  bit          m_err = 1'b0;

  task automatic m_complete();
    int idx;
    idx = int'((m_a >> 2) % DEPTH);
    if ((m_a % 4) != 0) begin
      m_rd = 0; m_err = 1'b1;
    end else if (m_w) begin
      m_mem[idx] = m_d; m_rd = 0; m_err = 1'b0;
    end else begin
      m_rd = m_mem[idx]; m_err = 1'b0;
    end
    m_pend = 1'b0;
    m_resp = 1'b1;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pend = 1'b0;
      m_resp = 1'b0;
    end else begin
      cyc++;
      if (m_resp) m_resp = 1'b0;
      else if (m_pend) begin
        if (cyc == m_done) m_complete();
      end else if (req_valid) begin
        m_w = req_write; m_a = req_addr; m_d = req_wdata;
        if (POSTED && req_write && (req_addr % 4) == 0) m_complete();
        else begin
          m_pend = 1'b1;
          m_done = cyc + LAT;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("req_ready", {31'd0, req_ready}, {31'd0, !m_pend && !m_resp});
    chk("resp_valid", {31'd0, resp_valid}, {31'd0, m_resp});
    chk("stall", {31'd0, stall}, {31'd0, m_pend || (!m_resp && req_valid)});
    if (m_resp) begin
      chk("resp_rdata", resp_rdata, m_rd);
      chk("resp_err", {31'd0, resp_err}, {31'd0, m_err});
    end
  end

  // One transaction from an IDLE cycle; returns data, error and the number
  // of edges from the accept edge to the edge that raised resp_valid.
  task automatic xact(input bit w, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output bit er, output int lat);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    #1;
    chk("stall_at_accept", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = ~w; req_addr = 32'hFFFF_FFF3; req_wdata = 32'hBAD0_BAD0;
    lat = 0;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    if (lat >= 20) begin
      checks++;
      $display("FAIL timeout: no resp_valid for addr %h, got 0 expected 1", a);
    end
    rd = resp_rdata;
    er = resp_err;
    chk("stall_in_resp", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
  endtask

  logic [31:0] rd;
  bit          er;
  int          lat;
  int          pulses;

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", {31'd0, resp_err}, 32'd0);

    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (resp_valid) pulses++;
    end
    chk("idle_pulses", pulses, 0);
    chk("idle_ready", {31'd0, req_ready}, 32'd1);

    xact(1'b1, 32'h10, 32'hDEAD_BEEF, rd, er, lat);
    chk("wr10_lat", lat, POSTED ? 0 : LAT);
    chk("wr10_rdata", rd, 32'd0);
    xact(1'b0, 32'h10, 32'h0, rd, er, lat);
    chk("rd10_lat", lat, LAT);
    chk("rd10_data", rd, 32'hDEAD_BEEF);
    chk("rd10_err", {31'd0, er}, 32'd0);

    xact(1'b0, 32'h13, 32'h0, rd, er, lat);
    chk("mis_rd_err", {31'd0, er}, 32'd1);
    chk("mis_rd_data", rd, 32'd0);
    xact(1'b1, 32'h12, 32'hFFFF_FFFF, rd, er, lat);
    chk("mis_wr_err", {31'd0, er}, 32'd1);
    chk("mis_wr_lat", lat, LAT);
    xact(1'b0, 32'h10, 32'h0, rd, er, lat);
    chk("rd10_after_mis", rd, 32'hDEAD_BEEF);

    xact(1'b1, 32'h400, 32'h55, rd, er, lat);
    xact(1'b0, 32'h000, 32'h0, rd, er, lat);
    chk("wrap_400_000", rd, 32'h55);
    xact(1'b1, 32'h3FC, 32'hA5A5_A5A5, rd, er, lat);
    xact(1'b0, 32'h7FC, 32'h0, rd, er, lat);
    chk("wrap_top_word", rd, 32'hA5A5_A5A5);

    xact(1'b1, 32'h20, 32'h11, rd, er, lat);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h99;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("busy_stall", {31'd0, stall}, POSTED ? 32'd0 : 32'd1);
    chk("busy_ready", {31'd0, req_ready}, 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_ready", {31'd0, req_ready}, 32'd1);
    chk("async_rst_stall", {31'd0, stall}, 32'd0);
    chk("async_rst_valid", {31'd0, resp_valid}, 32'd0);
    chk("async_rst_rdata", resp_rdata, 32'd0);
    chk("async_rst_err", {31'd0, resp_err}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    xact(1'b0, 32'h20, 32'h0, rd, er, lat);
    chk("rd20_after_abort", rd, POSTED ? 32'h99 : 32'h11);

    xact(1'b1, 32'h20, 32'h77, rd, er, lat);
    chk("wr20_lat", lat, POSTED ? 0 : LAT);
    xact(1'b0, 32'h20, 32'h0, rd, er, lat);
    chk("rd20_data", rd, 32'h77);
    chk("rd20_lat", lat, LAT);

    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10;
    pulses = 0;
    for (int i = 0; i < 2 * (LAT + 2); i++) begin
      @(posedge clk); #1;
      if (resp_valid) pulses++;
    end
    req_valid = 1'b0;
    chk("b2b_pulses", pulses, 2);
    repeat (4) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder at the far end of the pipeline's memory-stage request interface.
- Accepts one read or write request at a time from the MR/MW pipeline side and services it after a fixed, parameterised wait.
- Returns read data with a one-cycle response strobe.
- Drives a stall line that freezes the pipeline while a request is outstanding.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the backing array; power of 2, >= 2.
- LATENCY, 2, cycles from the request-accept edge to the response edge; integer >= 1.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  request present; driven by the pipeline's MemRead|MemWrite
- req_write  input  1  1 = write, 0 = read; sampled only on accept
- req_addr  input  32  byte address; the ALU result from the memory stage
- req_wdata  input  32  store data; the rt value from the memory stage
- req_ready  output  1  responder can accept a request this cycle
- resp_valid  output  1  one-cycle pulse: request completed
- resp_rdata  output  32  read data; valid only while resp_valid=1
- resp_err  output  1  pulses with resp_valid when the request was misaligned
- stall  output  1  pipeline must hold its memory-stage registers

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0; stall=0; latched request and counter cleared.
  - Array contents are not reset.
  - Reset during BUSY aborts the request and suppresses any pending write. No response is produced.
- FSM has three states: IDLE, BUSY, RESP.
- IDLE:
  - req_ready=1.
  - On an edge with req_valid=1: latch req_write, req_addr and req_wdata; load cnt=LATENCY-1; go to BUSY.
  - Request fields are ignored when req_valid=0.
- BUSY:
  - req_ready=0.
  - If cnt!=0: cnt decrements each edge.
  - If cnt==0: perform the access on that edge and go to RESP.
  - Changes on the req_* inputs while BUSY have no effect.
- RESP:
  - resp_valid=1 for exactly one cycle; req_ready=0.
  - Next edge returns to IDLE; resp_valid and resp_err clear.
  - A new request is accepted in the IDLE cycle that follows, never in RESP.
- Latency: with the accept edge as E0, resp_valid is high during the cycle after edge E(LATENCY). With LATENCY=1, resp_valid is high after E1.
- Access:
  - Word index = addr[2 +: log2(DEPTH_WORDS)]. Higher address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
  - Read: resp_rdata <= array[index].
  - Write: array[index] <= wdata and resp_rdata <= 0.
- Misaligned request (addr[1:0]!=0):
  - No array access.
  - resp_err=1 and resp_rdata=0 during the RESP cycle.
- stall = (state==BUSY) | (state==IDLE & req_valid).
  - stall=0 in RESP, so the pipeline advances exactly on the response cycle and captures resp_rdata.
- Back-to-back requests: each request costs LATENCY+2 cycles (accept, waits, resp). Never overlapped.
- Only a single request is outstanding at any time; there is no buffering beyond the one latched request.

Optional Feature:
- Macro: DMEM_POSTED_WRITE_EN.
- Defined:
  - Aligned writes are performed on the accept edge itself.
  - The FSM goes directly IDLE->RESP, skipping BUSY; write latency is 1 cycle regardless of LATENCY.
  - Reads and misaligned writes keep the normal path.
- Undefined: writes follow the full LATENCY path exactly like reads.

Test Plan:
- Reset then idle, req_valid=0 for 10 cycles -> req_ready=1, stall=0, resp_valid never asserts.
- LATENCY=2: write addr 0x10, data 0xDEADBEEF, then read addr 0x10 -> read resp_valid exactly 2 cycles after its accept edge with resp_rdata=0xDEADBEEF. stall is high in the accept and BUSY cycles and low in the RESP cycle.
- Misaligned read addr 0x13 -> resp_err=1, resp_rdata=0, array untouched; a following read of 0x10 still returns 0xDEADBEEF.
- Wrap-around with DEPTH_WORDS=256: write 0x55 to addr 0x400, read addr 0x000 -> resp_rdata=0x55.
- Assert reset during BUSY of a write to 0x20, which previously held 0x11 -> outputs return to reset values immediately (asynchronously); a later read of 0x20 returns 0x11.
- With DMEM_POSTED_WRITE_EN, write 0x20=0x77 -> resp_valid in the cycle after accept. A read of 0x20 immediately after returns 0x77 after LATENCY cycles.
